hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the five-stage MIPS pipeline. It drives the stall and flush controls of the IF/ID and ID/EX pipeline registers, and the forwarding mux selects for the D-stage branch comparator and the E-stage ALU. It also sequences the multi-cycle mult/div unit through a busy counter, and stalls any HI/LO-dependent instruction in D until the result is ready.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline.
// Combinational forward/stall decode plus a registered mult/div busy sequencer.
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic [4:0]       Rs_E,
    input  logic [4:0]       Rt_E,
    input  logic [4:0]       WriteReg_E,
    input  logic [4:0]       WriteReg_M,
    input  logic [4:0]       WriteReg_W,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             MemtoReg_E,
    input  logic             MemtoReg_M,
    input  logic             Branch_D,
    input  logic             PCSrc_D,
    input  logic             Jump_D,
    input  logic             MulDiv_D,
    input  logic             MulDivStart_E,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulDivBusy
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lwstall, branchstall, mdstall, stall;

    // $0 is hardwired to zero, so it never produces a dependency.
    function automatic logic match(input logic [4:0] x, input logic [4:0] r);
        return (x != 5'd0) && (x == r);
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWrite_M && match(WriteReg_M, Rs_E)) begin
            ForwardAE = 2'b10;
        end else if (RegWrite_W && match(WriteReg_W, Rs_E)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWrite_M && match(WriteReg_M, Rt_E)) begin
            ForwardBE = 2'b10;
        end else if (RegWrite_W && match(WriteReg_W, Rt_E)) begin
            ForwardBE = 2'b01;
        end
    end

    assign ForwardAD = RegWrite_M && match(WriteReg_M, Rs_D);
    assign ForwardBD = RegWrite_M && match(WriteReg_M, Rt_D);

    assign lwstall = MemtoReg_E && (match(Rt_E, Rs_D) || match(Rt_E, Rt_D));

    assign branchstall = Branch_D &&
        ((RegWrite_E && (match(WriteReg_E, Rs_D) || match(WriteReg_E, Rt_D))) ||
         (MemtoReg_M && (match(WriteReg_M, Rs_D) || match(WriteReg_M, Rt_D))));

    assign mdstall = MulDiv_D && (MulDivStart_E || MulDivBusy);

    // Reset forces the pipeline to drain: no holds, no IF/ID flush, bubble into E.
    assign stall  = !reset && (lwstall || branchstall || mdstall);
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall || reset;
    assign FlushD = !reset && (PCSrc_D || Jump_D) && !stall;

    assign MulDivBusy = (state_q == ST_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (MulDivStart_E && (MULDIV_CYCLES > 1)) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                // A new start while busy is ignored; mdstall keeps it from happening.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected output vectors are queued
// when stimulus is applied and compared when the outputs are sampled.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E;
    logic [4:0] WriteReg_E, WriteReg_M, WriteReg_W;
    logic       RegWrite_E, RegWrite_M, RegWrite_W;
    logic       MemtoReg_E, MemtoReg_M;
    logic       Branch_D, PCSrc_D, Jump_D, MulDiv_D, MulDivStart_E;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MulDivBusy;
    logic [1:0] ForwardAE, ForwardBE;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];

    hazard_ctrl #(
        .MULDIV_CYCLES(32),
        .CNT_W        (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Rs_D         (Rs_D),
        .Rt_D         (Rt_D),
        .Rs_E         (Rs_E),
        .Rt_E         (Rt_E),
        .WriteReg_E   (WriteReg_E),
        .WriteReg_M   (WriteReg_M),
        .WriteReg_W   (WriteReg_W),
        .RegWrite_E   (RegWrite_E),
        .RegWrite_M   (RegWrite_M),
        .RegWrite_W   (RegWrite_W),
        .MemtoReg_E   (MemtoReg_E),
        .MemtoReg_M   (MemtoReg_M),
        .Branch_D     (Branch_D),
        .PCSrc_D      (PCSrc_D),
        .Jump_D       (Jump_D),
        .MulDiv_D     (MulDiv_D),
        .MulDivStart_E(MulDivStart_E),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .ForwardAD    (ForwardAD),
        .ForwardBD    (ForwardBD),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .MulDivBusy   (MulDivBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {StallF, StallD, FlushD, FlushE, AD, BD, AE[1:0], BE[1:0], Busy}
    function automatic logic [10:0] vec(input logic sf, input logic sd, input logic fd,
                                        input logic fe, input logic ad, input logic bd,
                                        input logic [1:0] ae, input logic [1:0] be,
                                        input logic busy);
        return {sf, sd, fd, fe, ad, bd, ae, be, busy};
    endfunction

    task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (sf sd fd fe ad bd ae be busy)",
                     tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0;
        Rs_D = 5'd0; Rt_D = 5'd0; Rs_E = 5'd0; Rt_E = 5'd0;
        WriteReg_E = 5'd0; WriteReg_M = 5'd0; WriteReg_W = 5'd0;
        RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
        MemtoReg_E = 1'b0; MemtoReg_M = 1'b0;
        Branch_D = 1'b0; PCSrc_D = 1'b0; Jump_D = 1'b0;
        MulDiv_D = 1'b0; MulDivStart_E = 1'b0;
    endtask

    // Inputs are already driven for this cycle; queue the expectation, sample at the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [10:0] exp);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check_eq(got.tag, {StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
                           ForwardAE, ForwardBE, MulDivBusy}, got.exp);
        @(posedge clk);
        #1;
    endtask

    localparam logic [10:0] IDLE_V  = 11'b000_0000_0000;
    localparam logic [10:0] STALL_V = 11'b110_1000_0000;

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset_held", vec(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
        reset = 1'b0;
        step("after_reset", IDLE_V);

        // Forward priority in E
        RegWrite_M = 1; RegWrite_W = 1; WriteReg_M = 5; WriteReg_W = 5; Rs_E = 5;
        step("fwd_ae_m", vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
        RegWrite_M = 0;
        step("fwd_ae_w", vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
        Rs_E = 0;
        step("fwd_ae_r0", IDLE_V);
        RegWrite_M = 1; WriteReg_M = 6; Rt_E = 6; Rs_E = 5;
        step("fwd_be_m_ae_w", vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
        clear_inputs();

        // Forward in D
        RegWrite_M = 1; WriteReg_M = 7; Rt_D = 7;
        step("fwd_bd", vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
        WriteReg_M = 0; Rt_D = 0; Rs_D = 0;
        step("fwd_bd_r0", IDLE_V);
        clear_inputs();

        // Load-use
        MemtoReg_E = 1; Rt_E = 8; Rs_D = 8;
        step("lw_use_rs", STALL_V);
        Rs_D = 0; Rt_D = 8;
        step("lw_use_rt", STALL_V);
        Rt_E = 0; Rt_D = 0;
        step("lw_r0", IDLE_V);
        clear_inputs();

        // Branch after ALU op
        Branch_D = 1; Rt_D = 4; RegWrite_E = 1; WriteReg_E = 4;
        step("br_alu", STALL_V);
        WriteReg_E = 0; Rt_D = 0;
        step("br_alu_r0", IDLE_V);
        clear_inputs();

        // Branch after load: load in E, then in M, then resolved in W
        Branch_D = 1; Rs_D = 9;
        MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 9; Rt_E = 9;
        step("br_lw_e", STALL_V);
        MemtoReg_E = 0; RegWrite_E = 0; WriteReg_E = 0; Rt_E = 0;
        MemtoReg_M = 1; RegWrite_M = 1; WriteReg_M = 9;
        step("br_lw_m", vec(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0));
        MemtoReg_M = 0; RegWrite_M = 0; WriteReg_M = 0;
        RegWrite_W = 1; WriteReg_W = 9; PCSrc_D = 1;
        step("br_lw_taken", vec(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0));
        clear_inputs();

        // Jump
        Jump_D = 1;
        step("jump", vec(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0));
        MemtoReg_E = 1; Rt_E = 3; Rs_D = 3;
        step("jump_lwstall", STALL_V);
        clear_inputs();

        // Mult then mfhi: 32 stall cycles, busy for 31 starting after the issue cycle
        MulDiv_D = 1; MulDivStart_E = 1;
        for (int i = 0; i < 34; i++) begin
            logic s;
            logic b;
            s = (i < 32);
            b = (i >= 1) && (i <= 31);
            step($sformatf("md_cyc%0d", i), vec(s, s, 0, s, 0, 0, 2'b00, 2'b00, b));
            MulDivStart_E = 0;
        end
        clear_inputs();

        // Reset partway through a divide
        MulDiv_D = 1; MulDivStart_E = 1;
        for (int i = 0; i < 10; i++) begin
            step($sformatf("md_rst_cyc%0d", i), vec(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, i != 0));
            MulDivStart_E = 0;
        end
        reset = 1;
        step("md_rst_held", vec(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1));
        reset = 0;
        step("md_rst_after", IDLE_V);
        MulDiv_D = 0;
        step("md_rst_idle", IDLE_V);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
